// File: rtl/rosc_collector_pkg.sv
// Shared types and default parameters for the ring-oscillator entropy collector.
package rosc_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam int unsigned DEF_SEED_CYCLES = 16;
    localparam int unsigned DEF_SAMPLE_DIV  = 8;
    localparam int unsigned DEF_WORD_WIDTH  = 32;
    localparam int unsigned DEF_STUCK_LIMIT = 64;

endpackage

// File: rtl/rosc_sync2.sv
// Two-flop synchronizer for the asynchronous ring output.
module rosc_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; q is d delayed by two clock edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rosc_collector.sv
// Holds, seeds and releases the inverter ring, XOR-decimates its synchronized
// output into entropy bits, packs them into words and runs a stuck-output check.
module rosc_collector
    import rosc_collector_pkg::*;
#(
    parameter int unsigned SEED_CYCLES = DEF_SEED_CYCLES,
    parameter int unsigned SAMPLE_DIV  = DEF_SAMPLE_DIV,
    parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int unsigned STUCK_LIMIT = DEF_STUCK_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  osc_d,
    output logic                  osc_ctrl,
    output logic                  osc_seed,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_ack,
    output logic                  stuck_error
);

    localparam int unsigned BW = $clog2(WORD_WIDTH + 1);
    localparam logic [BW-1:0] BIT_FULL = BW'(WORD_WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_WIDTH - 1);
    localparam logic [7:0]    SEED_LAST = 8'(SEED_CYCLES - 1);
    localparam logic [7:0]    SAMP_LAST = 8'(SAMPLE_DIV - 1);
    localparam logic [15:0]   STUCK_LIM = 16'(STUCK_LIMIT);

    state_t state, state_next;

    logic                  s;
    logic                  s_prev;
    logic                  seed_bit;
    logic [7:0]            seed_cnt;
    logic [7:0]            samp_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  acc;
    logic [WORD_WIDTH-1:0] sreg;
    logic [15:0]           stuck_cnt;

    logic                  paused;
    logic                  collect;
    logic                  acc_next;
    logic                  bit_done;
    logic                  word_done;
    logic                  can_load;
    logic                  release_pending;
    logic                  seed_done;
    logic [15:0]           stuck_inc;
    logic                  stuck_hit;
    logic [WORD_WIDTH-1:0] sreg_next;

    rosc_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (osc_d),
        .q     (s)
    );

    // Datapath strobes derived from the current state and counters.
    always_comb begin
        paused          = (bit_cnt == BIT_FULL);
        collect         = enable && (state == ST_RUN) && !paused;
        acc_next        = acc ^ s;
        bit_done        = collect && (samp_cnt == SAMP_LAST);
        word_done       = bit_done && (bit_cnt == BIT_LAST);
        sreg_next       = {sreg[WORD_WIDTH-2:0], acc_next};
        can_load        = !data_valid || data_ack;
        release_pending = enable && (state == ST_RUN) && paused && data_ack;
        seed_done       = enable && (state == ST_SEED) && (seed_cnt == SEED_LAST);
        stuck_inc       = stuck_cnt + 16'd1;
        stuck_hit       = collect && (s == s_prev) && (stuck_inc == STUCK_LIM);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and ring control outputs.
    always_comb begin
        state_next = state;
        osc_ctrl   = 1'b1;
        osc_seed   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_SEED;
            end
            ST_SEED: begin
                osc_seed = seed_bit;
                if (seed_done) state_next = ST_RUN;
            end
            ST_RUN: begin
                osc_ctrl = 1'b0;
                if (stuck_hit) state_next = ST_ERROR;
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: state_next = ST_IDLE;
        endcase
        if (!enable) state_next = ST_IDLE;
    end

    // Seed sequencing, decimation, word packing, handshake and health check.
    always_ff @(posedge clk) begin
        if (reset) begin
            seed_bit    <= 1'b0;
            seed_cnt    <= '0;
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            acc         <= 1'b0;
            sreg        <= '0;
            s_prev      <= 1'b0;
            stuck_cnt   <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            stuck_error <= 1'b0;
        end else if (!enable || state == ST_IDLE) begin
            seed_cnt    <= '0;
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            acc         <= 1'b0;
            sreg        <= '0;
            s_prev      <= s;
            stuck_cnt   <= '0;
            data_valid  <= 1'b0;
            stuck_error <= 1'b0;
        end else begin
            s_prev <= s;
            if (state == ST_SEED) seed_cnt <= seed_cnt + 8'd1;
            if (seed_done) seed_bit <= ~seed_bit;

            if (data_valid && data_ack) data_valid <= 1'b0;

            if (collect) begin
                stuck_cnt <= (s != s_prev) ? 16'd0 : stuck_inc;
                if (stuck_hit) stuck_error <= 1'b1;
                if (bit_done) begin
                    samp_cnt <= '0;
                    acc      <= 1'b0;
                    // A completed word either loads now or parks in sreg with
                    // bit_cnt == WORD_WIDTH, which is what stalls collection.
                    if (word_done && can_load) begin
                        data       <= sreg_next;
                        data_valid <= 1'b1;
                        bit_cnt    <= '0;
                        sreg       <= '0;
                    end else begin
                        sreg    <= sreg_next;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end else begin
                    acc      <= acc_next;
                    samp_cnt <= samp_cnt + 8'd1;
                end
            end else if (release_pending) begin
                data       <= sreg;
                data_valid <= 1'b1;
                bit_cnt    <= '0;
                sreg       <= '0;
            end
        end
    end

endmodule

// File: doc/rosc_collector.md
# rosc_collector

Control-and-sampling end of a free-running inverter-ring entropy source. The block drives the ring's `ctrl`/`seed` inputs to hold, seed and release the oscillator, then samples its asynchronous output `d`. It compresses the samples by XOR decimation into entropy bits and packs them into 32-bit words delivered over a valid/ack handshake. A stuck-output health check forces the ring back into hold when the oscillator stops toggling.

## Interface
- `SEED_CYCLES`, 16: cycles the ring is held with `ctrl=1` before release; legal range 1..255.
- `SAMPLE_DIV`, 8: consecutive synchronized samples XORed into one entropy bit; legal range 1..255.
- `WORD_WIDTH`, 32: bits per output word.
- `STUCK_LIMIT`, 64: consecutive cycles without a change of the synchronized sample that trigger the stuck error; legal range 2..65535.

- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: level; 1 = run the source, 0 = hold the ring and clear the block.
- `osc_d` in 1: asynchronous ring output.
- `osc_ctrl` out 1: ring hold/seed control; 1 = ring forced to `osc_seed`.
- `osc_seed` out 1: seed value applied while `osc_ctrl=1`.
- `data` out WORD_WIDTH: collected entropy word.
- `data_valid` out 1: `data` holds an unconsumed word.
- `data_ack` in 1: consumer accepts `data` in a cycle where `data_valid=1`.
- `stuck_error` out 1: sticky health-check failure flag.

## Operation
- FSM states: IDLE, SEED, RUN, ERROR.
- IDLE: `osc_ctrl=1`. `enable=1` moves to SEED. Entry into IDLE clears the seed counter, sample counter, bit counter, shift register, `data_valid` and `stuck_error`.
- SEED: `osc_ctrl=1`, `osc_seed` = seed toggle bit. Lasts exactly SEED_CYCLES cycles, then moves to RUN. The seed toggle bit inverts on every SEED→RUN transition, so successive runs start from opposite ring states.
- RUN: `osc_ctrl=0`.
  - Every cycle, the synchronized sample `s` is XORed into accumulator `acc`, and the sample counter increments.
  - After SAMPLE_DIV samples, `acc` shifts into the shift register LSB (older bits toward MSB). Then `acc` clears and the bit counter increments.
  - When the bit counter reaches WORD_WIDTH:
    - If `data_valid=0`, or `data_ack=1` in the same cycle: the shift register transfers to `data`, `data_valid=1`, and the counters restart.
    - Otherwise the word is complete but pending: accumulation, sample counting and stuck counting pause with all counters held until the ack.
- Handshake: `data_valid` clears the cycle after `data_ack` with no pending completion. `data` is stable while `data_valid=1`. `data_ack` with `data_valid=0` is ignored.
- Health check (RUN only, not while paused): a 16-bit counter resets whenever `s` differs from its previous value. At STUCK_LIMIT the block sets `stuck_error=1` and moves to ERROR.
- ERROR: `osc_ctrl=1`, no collection. `data`/`data_valid` hold any pending word, which can still be acked. Exit only via `enable=0` (→ IDLE) or `reset`.
- `enable=0` in any state: next state IDLE. Any pending word is discarded.
- `reset`: all state and outputs are cleared. Takes priority over `enable`.

## Timing
- Reset values: `osc_ctrl=1`, `osc_seed=0`, `data=0`, `data_valid=0`, `stuck_error=0`; state IDLE; seed toggle bit 0.
- Synchronizer: 2 flops; `s` at cycle n equals `osc_d` sampled at cycle n-2.
- `enable` sampled 1 in IDLE at cycle 0 → SEED in cycles 1..SEED_CYCLES, RUN from cycle SEED_CYCLES+1 = R.
- The synchronizer is not flushed. The first SAMPLE_DIV samples of bit 0 are those of cycles R..R+SAMPLE_DIV-1.
- With no stall, `data_valid` rises at cycle R + WORD_WIDTH·SAMPLE_DIV. Subsequent words follow every WORD_WIDTH·SAMPLE_DIV cycles.
- `stuck_error` rises the cycle after the counter reaches STUCK_LIMIT. `osc_ctrl` goes to 1 in that same cycle.

## Structure
- Package `rosc_collector_pkg`: FSM state enum, and default constants for SEED_CYCLES, SAMPLE_DIV, WORD_WIDTH and STUCK_LIMIT.
- Sub-module `rosc_sync2`: the two-flop synchronizer for `osc_d`. It is kept separate so synthesis constraints (ASYNC_REG/keep) attach to one place.
- The ring itself is outside this block. Benches replace it with a behavioral `osc_d` driver.

## Test plan
- Reset mid-RUN with a half-built word → next cycle: all outputs at reset values, state IDLE, `osc_ctrl=1`.
- Defaults, `enable` high at cycle 0 → `osc_ctrl=1`, `osc_seed=0` for cycles 1..16; `osc_ctrl=0` from cycle 17. Second run (enable low, then high) seeds with `osc_seed=1`.
- `osc_d` high for exactly 1 cycle in every 8 → each bit is 1 → `data=0xFFFFFFFF`, `data_valid` rises at cycle 17+256. With `osc_d` high 2 of every 8 cycles → `data=0x00000000`.
- Hold `data_ack=0` across two word completions → first word stays on `data`, second-word collection pauses. Ack in the completion cycle → new word loads and `data_valid` stays 1.
- `osc_d` constant 0 in RUN → `stuck_error=1` 64 cycles after the last change, `osc_ctrl=1`. `enable=0` → `stuck_error` clears the next cycle.
- `enable` dropped during SEED → IDLE the next cycle; counters cleared; no `data_valid`.
